// File: rtl/graph_loader.sv
// graph_loader
//   Writer-side front end for the input feature-map memory (graph_mem).
//   It accepts one ROWS x COLS binary image as row words over a valid/ready
//   handshake. Each row is turned into COLS single-bit writes (bit 0 first),
//   each carrying its row/column address. After the last bit of the frame is
//   written, done pulses for one cycle so the control unit can start
//   convolution.
//
// Parameters
//   ROWS   : image rows per frame
//   COLS   : columns per row (also the row word width)
//   ADDR_W : width of the row/column address outputs (ROWS, COLS <= 2^ADDR_W)
//
// Ports
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   start        : one-cycle pulse that begins a frame; honoured only in IDLE
//   in_valid     : in_data holds a valid row word
//   in_data      : row word, bit c goes to column c
//   in_ready     : a row word is accepted this cycle
//   mem_en       : memory enable, high only on write cycles
//   mem_RW       : 1 = write, high only on write cycles
//   mem_rowaddr  : row address of the current write
//   mem_coladdr  : column address of the current write
//   mem_data_in  : bit being written
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse after the last write of the frame
//   ones_count   : (GRAPH_LOADER_POPCNT_EN only) number of 1s written in the frame
//
// Optional feature
//   Define GRAPH_LOADER_POPCNT_EN to add the ones_count output and its counter.
module graph_loader #(
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [COLS-1:0]   in_data,
    output logic              in_ready,
    output logic              mem_en,
    output logic              mem_RW,
    output logic [ADDR_W-1:0] mem_rowaddr,
    output logic [ADDR_W-1:0] mem_coladdr,
    output logic              mem_data_in,
    output logic              busy,
    output logic              done
`ifdef GRAPH_LOADER_POPCNT_EN
    ,
    output logic [$clog2(ROWS*COLS+1)-1:0] ones_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ROW,
        SHIFT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

    // Addresses are the counters themselves, so the counters must fit.
    generate
        if (ROWS > (1 << ADDR_W) || COLS > (1 << ADDR_W)) begin : g_param_check
            $error("graph_loader: ROWS and COLS must each be <= 2**ADDR_W");
        end
    endgenerate

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] row_cnt;
    logic [ADDR_W-1:0] col_cnt;
    logic [COLS-1:0]   shift_reg;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; every output is decoded from state and registered
    // counters only, so nothing on the memory side depends on in_valid/in_data
    // combinationally. Addresses read as 0 whenever no write is in progress.
    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        mem_en      = 1'b0;
        mem_RW      = 1'b0;
        mem_rowaddr = '0;
        mem_coladdr = '0;
        mem_data_in = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                mem_en      = 1'b1;
                mem_RW      = 1'b1;
                mem_rowaddr = row_cnt;
                mem_coladdr = col_cnt;
                mem_data_in = shift_reg[0];
                if (col_cnt == LAST_COL) begin
                    next_state = (row_cnt == LAST_ROW) ? DONE : WAIT_ROW;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Row/column counters and the row shift register. The captured word is
    // shifted right once per write so the bit for the current column is
    // always at position 0. The column counter parks at its last value at
    // the end of a row and is rewound when the next word is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt   <= '0;
            col_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_cnt <= '0;
                    end
                end
                WAIT_ROW: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        col_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    if (col_cnt != LAST_COL) begin
                        col_cnt <= col_cnt + ADDR_W'(1);
                    end else if (row_cnt != LAST_ROW) begin
                        row_cnt <= row_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GRAPH_LOADER_POPCNT_EN
    localparam int PC_W = $clog2(ROWS*COLS+1);

    // Ones counter: cleared on an accepted start, bumped on every write of a
    // 1, and otherwise left alone so it holds the frame total after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_count <= '0;
        end else if (state == IDLE && start) begin
            ones_count <= '0;
        end else if (state == SHIFT && shift_reg[0]) begin
            ones_count <= ones_count + PC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_graph_loader.sv
// tb_graph_loader
//   Testbench for graph_loader. Two instances run side by side on one clock:
//   lane 0 uses the 5x5 defaults, lane 1 overrides ROWS=3, COLS=4.
//   For every lane the bench lays out a cycle-by-cycle timeline of what it
//   drives and what the outputs must be, derived from the frame rules:
//   start in cycle s, row r is handed over at cycle
//   s+1+r*(COLS+1)+(idle cycles inserted so far), its bits are written in the
//   COLS cycles that follow, and done follows the last write.
//   A single compare process checks every output against that timeline each
//   cycle; a few literal expectations afterwards pin the timeline itself.
module tb_graph_loader;

    localparam int MAXC = 160;
    localparam int NL   = 2;

    int lane_rows [NL] = '{5, 3};
    int lane_cols [NL] = '{5, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, in_valid_a;
    logic [4:0] in_data_a;
    logic       in_ready_a, mem_en_a, mem_rw_a, mem_data_in_a, busy_a, done_a;
    logic [4:0] mem_rowaddr_a, mem_coladdr_a;

    logic       rst_b, start_b, in_valid_b;
    logic [3:0] in_data_b;
    logic       in_ready_b, mem_en_b, mem_rw_b, mem_data_in_b, busy_b, done_b;
    logic [4:0] mem_rowaddr_b, mem_coladdr_b;

`ifdef GRAPH_LOADER_POPCNT_EN
    logic [4:0] ones_count_a;
    logic [3:0] ones_count_b;
`endif

    graph_loader dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .start       (start_a),
        .in_valid    (in_valid_a),
        .in_data     (in_data_a),
        .in_ready    (in_ready_a),
        .mem_en      (mem_en_a),
        .mem_RW      (mem_rw_a),
        .mem_rowaddr (mem_rowaddr_a),
        .mem_coladdr (mem_coladdr_a),
        .mem_data_in (mem_data_in_a),
        .busy        (busy_a),
        .done        (done_a)
`ifdef GRAPH_LOADER_POPCNT_EN
        ,
        .ones_count  (ones_count_a)
`endif
    );

    graph_loader #(.ROWS(3), .COLS(4), .ADDR_W(5)) dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .start       (start_b),
        .in_valid    (in_valid_b),
        .in_data     (in_data_b),
        .in_ready    (in_ready_b),
        .mem_en      (mem_en_b),
        .mem_RW      (mem_rw_b),
        .mem_rowaddr (mem_rowaddr_b),
        .mem_coladdr (mem_coladdr_b),
        .mem_data_in (mem_data_in_b),
        .busy        (busy_b),
        .done        (done_b)
`ifdef GRAPH_LOADER_POPCNT_EN
        ,
        .ones_count  (ones_count_b)
`endif
    );

    // Stimulus and expectation timelines, indexed [lane][cycle].
    logic       drv_rst   [NL][MAXC];
    logic       drv_start [NL][MAXC];
    logic       drv_valid [NL][MAXC];
    logic [7:0] drv_data  [NL][MAXC];
    logic       exp_ready [NL][MAXC];
    logic       exp_busy  [NL][MAXC];
    logic       exp_en    [NL][MAXC];
    logic       exp_done  [NL][MAXC];
    logic       exp_zero  [NL][MAXC];
    logic       exp_bit   [NL][MAXC];
    logic [4:0] exp_row   [NL][MAXC];
    logic [4:0] exp_col   [NL][MAXC];
    int         exp_pop   [NL][MAXC];

    // What the DUTs actually showed, for the literal checks at the end.
    logic       obs_ready [NL][MAXC];
    logic       obs_busy  [NL][MAXC];
    logic       obs_en    [NL][MAXC];
    logic       obs_done  [NL][MAXC];
    logic       obs_bit   [NL][MAXC];
    logic [4:0] obs_row   [NL][MAXC];
    logic [4:0] obs_col   [NL][MAXC];
    int         obs_pop   [NL][MAXC];

    int checks  = 0;
    int errors  = 0;
    int cur     = 0;
    bit running = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected, input int t);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, t, actual, expected);
        end
    endtask

    task automatic clearFrom(input int ln, input int t0);
        for (int k = t0; k < MAXC; k++) begin
            drv_rst[ln][k]   = 1'b0;
            drv_start[ln][k] = 1'b0;
            drv_valid[ln][k] = 1'b0;
            drv_data[ln][k]  = 8'h00;
            exp_ready[ln][k] = 1'b0;
            exp_busy[ln][k]  = 1'b0;
            exp_en[ln][k]    = 1'b0;
            exp_done[ln][k]  = 1'b0;
            exp_zero[ln][k]  = 1'b0;
            exp_bit[ln][k]   = 1'b0;
            exp_row[ln][k]   = 5'd0;
            exp_col[ln][k]   = 5'd0;
            exp_pop[ln][k]   = 0;
        end
    endtask

    // Reset held for len cycles from t0: everything after is idle and zero.
    task automatic planReset(input int ln, input int t0, input int len);
        clearFrom(ln, t0);
        for (int k = t0; k < t0 + len; k++) begin
            drv_rst[ln][k]  = 1'b1;
            exp_zero[ln][k] = 1'b1;
        end
    endtask

    // Frame starting at cycle s; gaps[r] idle handshake cycles before row r.
    // Outside the handshake cycle, in_valid is held high with junk data,
    // except during the gap cycles where it is low.
    task automatic planFrame(input int ln, input int s, input logic [7:0] words [5],
                             input int gaps [5], input logic [7:0] junk, output int d);
        int h;
        int p;
        int nr;
        int nc;
        nr = lane_rows[ln];
        nc = lane_cols[ln];
        clearFrom(ln, s);
        drv_start[ln][s] = 1'b1;
        h = s + 1;
        for (int r = 0; r < nr; r++) begin
            h = h + gaps[r];
            for (int k = h - gaps[r]; k <= h; k++) exp_ready[ln][k] = 1'b1;
            drv_valid[ln][h] = 1'b1;
            drv_data[ln][h]  = words[r];
            for (int c = 0; c < nc; c++) begin
                exp_en[ln][h+1+c]  = 1'b1;
                exp_row[ln][h+1+c] = 5'(r);
                exp_col[ln][h+1+c] = 5'(c);
                exp_bit[ln][h+1+c] = words[r][c];
            end
            h = h + nc + 1;
        end
        d = h;
        exp_done[ln][d] = 1'b1;
        for (int k = s + 1; k <= d; k++) exp_busy[ln][k] = 1'b1;
        for (int k = s; k <= d; k++) begin
            if (!exp_ready[ln][k]) begin
                drv_valid[ln][k] = 1'b1;
                drv_data[ln][k]  = junk;
            end
        end
        p = 0;
        for (int k = s + 1; k < MAXC; k++) begin
            exp_pop[ln][k] = p;
            if (exp_en[ln][k] && exp_bit[ln][k]) p++;
        end
    endtask

    task automatic applyStimulus(input int t);
        cur        = t;
        rst_a      = drv_rst[0][t];
        start_a    = drv_start[0][t];
        in_valid_a = drv_valid[0][t];
        in_data_a  = drv_data[0][t][4:0];
        rst_b      = drv_rst[1][t];
        start_b    = drv_start[1][t];
        in_valid_b = drv_valid[1][t];
        in_data_b  = drv_data[1][t][3:0];
    endtask

    function automatic int firstDone(input int ln, input int t0);
        for (int t = t0; t < MAXC; t++) if (obs_done[ln][t]) return t;
        return -1000;
    endfunction

    function automatic int countWrites(input int ln, input int t0, input int t1);
        int n = 0;
        for (int t = t0; t <= t1; t++) if (obs_en[ln][t]) n++;
        return n;
    endfunction

    function automatic int countReady(input int ln, input int t0, input int t1);
        int n = 0;
        for (int t = t0; t <= t1; t++) if (obs_ready[ln][t]) n++;
        return n;
    endfunction

    function automatic int rowWord(input int ln, input int r, input int t0, input int t1);
        int w = 0;
        for (int t = t0; t <= t1; t++)
            if (obs_en[ln][t] && obs_row[ln][t] == 5'(r) && obs_bit[ln][t])
                w = w | (1 << obs_col[ln][t]);
        return w;
    endfunction

    function automatic int maxAddr(input int ln, input bit use_col, input int t0, input int t1);
        int m = -1;
        int v;
        for (int t = t0; t <= t1; t++) begin
            if (obs_en[ln][t]) begin
                v = use_col ? int'(obs_col[ln][t]) : int'(obs_row[ln][t]);
                if (v > m) m = v;
            end
        end
        return m;
    endfunction

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (running) begin
            checkOutput("a_busy", busy_a, exp_busy[0][cur], cur);
            checkOutput("a_in_ready", in_ready_a, exp_ready[0][cur], cur);
            checkOutput("a_mem_en", mem_en_a, exp_en[0][cur], cur);
            checkOutput("a_mem_RW", mem_rw_a, exp_en[0][cur], cur);
            checkOutput("a_done", done_a, exp_done[0][cur], cur);
            if (exp_en[0][cur] || exp_zero[0][cur]) begin
                checkOutput("a_rowaddr", mem_rowaddr_a, exp_row[0][cur], cur);
                checkOutput("a_coladdr", mem_coladdr_a, exp_col[0][cur], cur);
                checkOutput("a_data_in", mem_data_in_a, exp_bit[0][cur], cur);
            end
            checkOutput("b_busy", busy_b, exp_busy[1][cur], cur);
            checkOutput("b_in_ready", in_ready_b, exp_ready[1][cur], cur);
            checkOutput("b_mem_en", mem_en_b, exp_en[1][cur], cur);
            checkOutput("b_mem_RW", mem_rw_b, exp_en[1][cur], cur);
            checkOutput("b_done", done_b, exp_done[1][cur], cur);
            if (exp_en[1][cur] || exp_zero[1][cur]) begin
                checkOutput("b_rowaddr", mem_rowaddr_b, exp_row[1][cur], cur);
                checkOutput("b_coladdr", mem_coladdr_b, exp_col[1][cur], cur);
                checkOutput("b_data_in", mem_data_in_b, exp_bit[1][cur], cur);
            end
`ifdef GRAPH_LOADER_POPCNT_EN
            checkOutput("a_ones_count", ones_count_a, exp_pop[0][cur], cur);
            checkOutput("b_ones_count", ones_count_b, exp_pop[1][cur], cur);
            obs_pop[0][cur] = int'(ones_count_a);
            obs_pop[1][cur] = int'(ones_count_b);
`endif
            obs_ready[0][cur] = in_ready_a;
            obs_busy[0][cur]  = busy_a;
            obs_en[0][cur]    = mem_en_a;
            obs_done[0][cur]  = done_a;
            obs_bit[0][cur]   = mem_data_in_a;
            obs_row[0][cur]   = mem_rowaddr_a;
            obs_col[0][cur]   = mem_coladdr_a;
            obs_ready[1][cur] = in_ready_b;
            obs_busy[1][cur]  = busy_b;
            obs_en[1][cur]    = mem_en_b;
            obs_done[1][cur]  = done_b;
            obs_bit[1][cur]   = mem_data_in_b;
            obs_row[1][cur]   = mem_rowaddr_b;
            obs_col[1][cur]   = mem_coladdr_b;
        end
    end

    initial begin
        logic [7:0] w1 [5];
        logic [7:0] w2 [5];
        logic [7:0] wb [5];
        int         g0 [5];
        int         g3 [5];
        int         d;

        rst_a = 1'b1; start_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
        rst_b = 1'b1; start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
        for (int ln = 0; ln < NL; ln++) begin
            for (int k = 0; k < MAXC; k++) begin
                obs_ready[ln][k] = 1'b0; obs_busy[ln][k] = 1'b0;
                obs_en[ln][k]    = 1'b0; obs_done[ln][k] = 1'b0;
                obs_bit[ln][k]   = 1'b0; obs_row[ln][k]  = 5'd0;
                obs_col[ln][k]   = 5'd0; obs_pop[ln][k]  = 0;
            end
            clearFrom(ln, 0);
            planReset(ln, 0, 3);
        end

        w1 = '{8'h15, 8'h0A, 8'h1F, 8'h00, 8'h11};
        w2 = '{8'h06, 8'h19, 8'h0E, 8'h10, 8'h03};
        wb = '{8'h09, 8'h06, 8'h0D, 8'h00, 8'h00};
        g0 = '{0, 0, 0, 0, 0};
        g3 = '{0, 0, 0, 7, 0};

        // Lane 0: frame cut by reset at row 2 col 3, then full frame,
        // back-pressured frame with ignored starts, back-to-back frame.
        planFrame(0, 5, w1, g0, 8'h0C, d);
        planReset(0, 22, 1);
        planFrame(0, 25, w1, g0, 8'h0C, d);
        planFrame(0, 60, w1, g3, 8'h0C, d);
        drv_start[0][64] = 1'b1;
        drv_start[0][98] = 1'b1;
        planFrame(0, 99, w2, g0, 8'h1F, d);
        // Lane 1: one 3x4 frame.
        planFrame(1, 10, wb, g0, 8'h0F, d);

        running = 1'b1;
        for (int t = 0; t < MAXC; t++) begin
            @(posedge clk);
            #1;
            applyStimulus(t);
        end
        @(posedge clk);
        #1;
        running = 1'b0;

        checkOutput("reset_busy", obs_busy[0][1], 0, 1);
        checkOutput("midshift_reset_busy", obs_busy[0][22], 0, 22);
        checkOutput("midshift_reset_mem_en", obs_en[0][22], 0, 22);
        checkOutput("full_frame_writes", countWrites(0, 25, 56), 25, 25);
        checkOutput("full_frame_row0", rowWord(0, 0, 25, 56), 5'b10101, 25);
        checkOutput("full_frame_row2", rowWord(0, 2, 25, 56), 5'b11111, 25);
        checkOutput("full_frame_done_latency", firstDone(0, 25) - 25, 31, 25);
        checkOutput("backpressure_gap_writes", countWrites(0, 79, 85), 0, 79);
        checkOutput("backpressure_gap_ready", countReady(0, 79, 85), 7, 79);
        checkOutput("backpressure_done_latency", firstDone(0, 60) - 60, 38, 60);
        checkOutput("backpressure_row3", rowWord(0, 3, 60, 98), 5'b00000, 60);
        checkOutput("back_to_back_done_latency", firstDone(0, 99) - 99, 31, 99);
        checkOutput("junk_ignored_row0", rowWord(0, 0, 99, 130), 5'b00110, 99);
        checkOutput("junk_ignored_row3", rowWord(0, 3, 99, 130), 5'b10000, 99);
        checkOutput("small_writes", countWrites(1, 10, 26), 12, 10);
        checkOutput("small_max_col", maxAddr(1, 1'b1, 10, 26), 3, 10);
        checkOutput("small_max_row", maxAddr(1, 1'b0, 10, 26), 2, 10);
        checkOutput("small_done_latency", firstDone(1, 10) - 10, 16, 10);
`ifdef GRAPH_LOADER_POPCNT_EN
        checkOutput("full_frame_ones_count", obs_pop[0][56], 12, 56);
        checkOutput("small_ones_count", obs_pop[1][26], 7, 26);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
